// File: rtl/cpu_run_controller.sv
// Run controller for the single-cycle Processor: sequences core reset, bounds the run,
// captures every change of the core's out bus into a FIFO trace buffer and detects halt.
module cpu_run_controller #(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 16,
    parameter int RST_CYCLES    = 2,
    parameter int MAX_CYCLES    = 50,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       core_out,
    output logic                   core_rst,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] trace_count,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic                   overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int YW = $clog2(MAX_CYCLES + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [YW-1:0] CYC_LIM  = YW'(MAX_CYCLES);
    localparam logic [SW-1:0] STB_LIM  = SW'(STABLE_CYCLES);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [RW-1:0]    rst_cnt_reg;
    logic [YW-1:0]    cyc_cnt_reg, cyc_inc;
    logic [SW-1:0]    stable_cnt_reg, stable_next;
    logic [WIDTH-1:0] prev_reg;
    logic [PW-1:0]    wptr_reg, rptr_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] mem [DEPTH];

    logic start_ok, in_run, first_run, changed, capture;
    logic halt, tmo, wr_ok, drop, rd_ok, rst_done;

    always_comb begin
        start_ok    = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
        in_run      = (state_reg == S_RUN);
        first_run   = in_run && (cyc_cnt_reg == '0);
        changed     = (core_out != prev_reg);
        capture     = in_run && (first_run || changed);
        cyc_inc     = (cyc_cnt_reg == CYC_LIM) ? cyc_cnt_reg : cyc_cnt_reg + 1'b1;
        stable_next = '0;
        if (!(first_run || changed))
            stable_next = (stable_cnt_reg == STB_LIM) ? stable_cnt_reg : stable_cnt_reg + 1'b1;
        // Halt takes priority so a coincident timeout leaves the timeout flag clear.
        halt        = in_run && (stable_next == STB_LIM);
        tmo         = in_run && (cyc_inc == CYC_LIM) && !halt;
        wr_ok       = capture && (count_reg != FULL);
        drop        = capture && (count_reg == FULL);
        rd_ok       = rd_en && (count_reg != '0) && !start_ok;
        rst_done    = (rst_cnt_reg == RST_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S_IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start_ok) state_next = S_RESET;
            S_RESET: if (rst_done) state_next = S_RUN;
            S_RUN:   if (halt || tmo) state_next = S_DONE;
            S_DONE:  if (start_ok) state_next = S_RESET;
            default: state_next = S_IDLE;
        endcase
    end

    assign core_rst    = (state_reg != S_RUN);
    assign busy        = (state_reg == S_RESET) || (state_reg == S_RUN);
    assign done        = (state_reg == S_DONE);
    assign trace_count = count_reg;

    // Trace storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr_reg] <= core_out;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_cnt_reg    <= '0;
            cyc_cnt_reg    <= '0;
            stable_cnt_reg <= '0;
            prev_reg       <= '0;
            wptr_reg       <= '0;
            rptr_reg       <= '0;
            count_reg      <= '0;
            rd_data        <= '0;
            rd_valid       <= 1'b0;
            timeout        <= 1'b0;
            overflow       <= 1'b0;
        end else if (start_ok) begin
            rst_cnt_reg    <= '0;
            cyc_cnt_reg    <= '0;
            stable_cnt_reg <= '0;
            wptr_reg       <= '0;
            rptr_reg       <= '0;
            count_reg      <= '0;
            rd_valid       <= 1'b0;
            timeout        <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            if ((state_reg == S_RESET) && !rst_done)
                rst_cnt_reg <= rst_cnt_reg + 1'b1;
            if (in_run) begin
                cyc_cnt_reg    <= cyc_inc;
                stable_cnt_reg <= stable_next;
                prev_reg       <= core_out;
            end
            rd_valid <= rd_ok;
            if (rd_ok) begin
                rd_data  <= mem[rptr_reg];
                rptr_reg <= rptr_reg + 1'b1;
            end
            if (wr_ok) wptr_reg <= wptr_reg + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (drop) overflow <= 1'b1;
            if (tmo)  timeout  <= 1'b1;
        end
    end

endmodule
